// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the two-port RAM arbiter.
//   - Grant encoding: a one-hot pair, bit 0 = port A, bit 1 = port B.
//   - Priority mode selectors for the rr_mode_g parameter.
//   - Round-robin pointer type and its update helper.
package ram_port_arbiter_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;

  localparam int NUM_PORTS = 2;
  localparam int PORT_A    = 0;
  localparam int PORT_B    = 1;

  // Which port wins the next tie in round-robin mode.
  typedef enum logic {
    PREFER_A = 1'b0,
    PREFER_B = 1'b1
  } rr_ptr_e;

  // After a grant the other port becomes preferred; with no grant the
  // pointer keeps its value.
  function automatic rr_ptr_e next_ptr(input logic [1:0] gnt, input rr_ptr_e cur);
    rr_ptr_e nxt;
    nxt = cur;
    case (gnt)
      GNT_A:   nxt = PREFER_B;
      GNT_B:   nxt = PREFER_A;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_grant.sv
// arb2_grant
//   Combinational 2-way grant.
//   Ports:
//     elig     in  [1:0]  eligible requesters (bit 0 = A, bit 1 = B)
//     rr_mode  in         1 = round-robin on ties, 0 = A always wins ties
//     prefer   in         round-robin pointer (which port wins the next tie)
//     gnt      out [1:0]  one-hot grant, GNT_NONE when nothing is eligible
module arb2_grant
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       rr_mode,
  input  rr_ptr_e    prefer,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (elig)
      2'b01:   gnt = GNT_A;
      2'b10:   gnt = GNT_B;
      2'b11:   gnt = (rr_mode && (prefer == PREFER_B)) ? GNT_B : GNT_A;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM (1-cycle registered read,
//   write-through) between requester A (CPU) and requester B (video/DMA).
//   A request seen in cycle N is issued to the RAM during N+1 (x_ack high),
//   read data comes back on ram_q in N+2 and is presented on x_rdata with a
//   one-cycle x_rvalid strobe in N+3.
//   Ports:
//     clock, reset_n           clock; asynchronous active-low reset
//     a_req/a_we/a_addr/a_wdata   port A command (held until a_ack)
//     a_ack, a_rvalid, a_rdata    port A issue pulse, read strobe, read data
//     b_*                         same set for port B
//     ram_address/ram_data/ram_wren  RAM command outputs
//     ram_q                       RAM read data input
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8,
  parameter int rr_mode_g    = PRI_RR
) (
  input  logic                    clock,
  input  logic                    reset_n,

  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [addr_width_g-1:0] a_addr,
  input  logic [data_width_g-1:0] a_wdata,
  output logic                    a_ack,
  output logic                    a_rvalid,
  output logic [data_width_g-1:0] a_rdata,

  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [addr_width_g-1:0] b_addr,
  input  logic [data_width_g-1:0] b_wdata,
  output logic                    b_ack,
  output logic                    b_rvalid,
  output logic [data_width_g-1:0] b_rdata,

  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);

  localparam logic RR_ENABLE = (rr_mode_g == PRI_RR);

  // Per-port views of the two requester interfaces, indexed by PORT_A/PORT_B.
  logic [NUM_PORTS-1:0]    req_vec;
  logic [NUM_PORTS-1:0]    we_vec;
  logic [addr_width_g-1:0] addr_vec  [NUM_PORTS];
  logic [data_width_g-1:0] wdata_vec [NUM_PORTS];
  logic [data_width_g-1:0] rdata_vec [NUM_PORTS];
  logic [NUM_PORTS-1:0]    rvalid_vec;

  logic [NUM_PORTS-1:0]    elig;
  logic [1:0]              gnt;

  // Issue stage (visible to the RAM during N+1).
  logic [NUM_PORTS-1:0]    ack_reg;
  logic [addr_width_g-1:0] ram_address_reg, ram_address_next;
  logic [data_width_g-1:0] ram_data_reg, ram_data_next;
  logic                    ram_wren_reg, ram_wren_next;
  rr_ptr_e                 ptr_reg, ptr_next;

  // Owner tags of reads in flight: tag1 lines up with the issue cycle,
  // tag2 with the cycle in which ram_q carries the data.
  logic [NUM_PORTS-1:0]    rd_tag1_reg, rd_tag1_next;
  logic [NUM_PORTS-1:0]    rd_tag2_reg;

  assign req_vec[PORT_A]   = a_req;
  assign req_vec[PORT_B]   = b_req;
  assign we_vec[PORT_A]    = a_we;
  assign we_vec[PORT_B]    = b_we;
  assign addr_vec[PORT_A]  = a_addr;
  assign addr_vec[PORT_B]  = b_addr;
  assign wdata_vec[PORT_A] = a_wdata;
  assign wdata_vec[PORT_B] = b_wdata;

  arb2_grant u_grant (
    .elig    (elig),
    .rr_mode (RR_ENABLE),
    .prefer  (ptr_reg),
    .gnt     (gnt)
  );

  // Issue mux. On idle cycles the address/data lines keep their last value
  // and only wren drops.
  always_comb begin
    ram_address_next = ram_address_reg;
    ram_data_next    = ram_data_reg;
    ram_wren_next    = 1'b0;
    case (gnt)
      GNT_A: begin
        ram_address_next = addr_vec[PORT_A];
        ram_data_next    = wdata_vec[PORT_A];
        ram_wren_next    = we_vec[PORT_A];
      end
      GNT_B: begin
        ram_address_next = addr_vec[PORT_B];
        ram_data_next    = wdata_vec[PORT_B];
        ram_wren_next    = we_vec[PORT_B];
      end
      default: begin
        ram_wren_next = 1'b0;
      end
    endcase
  end

  // gnt is one-hot, so masking with ~we leaves the owner bit of a read only.
  assign rd_tag1_next = gnt & ~we_vec;
  assign ptr_next     = next_ptr(gnt, ptr_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg         <= '0;
      ram_address_reg <= '0;
      ram_data_reg    <= '0;
      ram_wren_reg    <= 1'b0;
      ptr_reg         <= PREFER_A;
      rd_tag1_reg     <= '0;
      rd_tag2_reg     <= '0;
    end else begin
      ack_reg         <= gnt;
      ram_address_reg <= ram_address_next;
      ram_data_reg    <= ram_data_next;
      ram_wren_reg    <= ram_wren_next;
      ptr_reg         <= ptr_next;
      rd_tag1_reg     <= rd_tag1_next;
      rd_tag2_reg     <= rd_tag1_reg;
    end
  end

  // Per-port eligibility and read-return steering.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [data_width_g-1:0] rdata_reg;
      logic                    rvalid_reg;

      // A port in its own ack cycle is presenting either nothing or its
      // next command, which only becomes eligible one cycle later.
      assign elig[gi] = req_vec[gi] & ~ack_reg[gi];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_tag2_reg[gi];
          if (rd_tag2_reg[gi]) begin
            rdata_reg <= ram_q;
          end
        end
      end

      assign rdata_vec[gi]  = rdata_reg;
      assign rvalid_vec[gi] = rvalid_reg;
    end
  endgenerate

  assign a_ack       = ack_reg[PORT_A];
  assign b_ack       = ack_reg[PORT_B];
  assign a_rvalid    = rvalid_vec[PORT_A];
  assign b_rvalid    = rvalid_vec[PORT_B];
  assign a_rdata     = rdata_vec[PORT_A];
  assign b_rdata     = rdata_vec[PORT_B];
  assign ram_address = ram_address_reg;
  assign ram_data    = ram_data_reg;
  assign ram_wren    = ram_wren_reg;

endmodule
